// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with runtime frame format.
// Define UART_TX_BREAK_EN to add break generation driven by brk.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [3:0]                    cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic                          tx_en,
    input  logic                          wr_valid,
    input  logic [8:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          brk,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BRK
`endif
    } state_t;
    logic [8:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [AW:0]          r_count;
    state_t               r_state;
    logic                 r_tx, r_busy, r_pen, r_par, r_stop2;
    logic [DIV_WIDTH-1:0] r_cnt, r_div, w_div;
    logic [3:0]           r_d, r_idx, w_d;
    logic [8:0]           r_shift, w_head, w_mask;
    logic                 w_push, w_pop, w_tick, w_last, w_idle_go;
    assign wr_ready   = ~r_count[AW];
    assign fifo_count = r_count;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign w_push     = wr_valid && !r_count[AW];
    assign w_head     = r_mem[r_rp];
    assign w_div      = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : baud_div;
    assign w_d        = (cfg_data_bits < 4'd5) ? 4'd5 : (cfg_data_bits > 4'd9) ? 4'd9 : cfg_data_bits;
    assign w_mask     = 9'h1ff >> (4'd9 - w_d);
    assign w_tick     = r_cnt == r_div - DIV_WIDTH'(1);
    assign w_last     = r_state == S_STOP && w_tick && (!r_stop2 || r_idx[0]);
`ifdef UART_TX_BREAK_EN
    logic r_rel;
    assign w_idle_go = (r_state == S_IDLE && !brk) || (r_state == S_BRK && r_rel && w_tick);
`else
    logic w_unused;
    assign w_unused  = brk;
    assign w_idle_go = r_state == S_IDLE;
`endif
    assign w_pop = tx_en && r_count != '0 && (w_idle_go || w_last);
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= DIV_WIDTH'(1);
            r_idx   <= '0;
            r_d     <= 4'd8;
            r_shift <= '0;
            r_pen   <= 1'b0;
            r_par   <= 1'b0;
            r_stop2 <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_rel   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= w_div;
            r_idx   <= '0;
            r_d     <= w_d;
            r_shift <= w_head;
            r_pen   <= cfg_parity_en;
            r_par   <= ^(w_head & w_mask) ^ cfg_parity_odd;
            r_stop2 <= cfg_stop2;
`ifdef UART_TX_BREAK_EN
            r_rel   <= 1'b0;
        end else if (r_state == S_IDLE && brk) begin
            r_state <= S_BRK;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= w_div;
            r_rel   <= 1'b0;
        end else if (r_state == S_BRK) begin
            if (!r_rel) begin
                if (!brk) begin
                    r_rel <= 1'b1;
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                end
            end else if (w_tick) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_rel   <= 1'b0;
            end else r_cnt <= r_cnt + DIV_WIDTH'(1);
`endif
        end else if (r_state != S_IDLE) begin
            r_cnt <= w_tick ? '0 : r_cnt + DIV_WIDTH'(1);
            if (w_tick)
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= 4'd1;
                    end
                    S_DATA:
                        if (r_idx != r_d) begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 4'd1;
                        end else if (r_pen) begin
                            r_state <= S_PAR;
                            r_tx    <= r_par;
                        end else begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                            r_idx   <= '0;
                        end
                    S_PAR: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                        r_idx   <= '0;
                    end
                    S_STOP:
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else r_idx <= 4'd1;
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;
    logic        clk, rst;
    logic [15:0] baud_div;
    logic [3:0]  cfg_data_bits;
    logic        cfg_parity_en, cfg_parity_odd, cfg_stop2, tx_en;
    logic        wr_valid, wr_ready, brk, tx, busy;
    logic [8:0]  wr_data;
    logic [4:0]  fifo_count;
    int          n_checks, n_errs;
    uart_tx_fifo dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
        .tx_en(tx_en), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .brk(brk), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic exp_bit(input logic [8:0] w, input int d, input logic pe, input logic po, input int b);
        logic [8:0] m;
        m = 9'h1ff >> (9 - d);
        if (b == 0) return 1'b0;
        if (b <= d) return w[b-1];
        if (pe && b == d + 1) return (^(w & m)) ^ po;
        return 1'b1;
    endfunction
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (wr_ready !== 1'b1) begin n_errs++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_8n1;
        logic [9:0] e;
        e = 10'b1010101010;
        baud_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; tx_en = 1'b1;
        wr_valid = 1'b1; wr_data = 9'h055;
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++; if (fifo_count !== 5'd1) begin n_errs++; $display("FAIL 8n1_count_push: got %0d expected 1", fifo_count); end
        n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL 8n1_tx_before_pop: got %b expected 1", tx); end
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            n_checks++; if (tx !== e[k/4]) begin n_errs++; $display("FAIL 8n1_tx k=%0d: got %b expected %b", k, tx, e[k/4]); end
            n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL 8n1_busy k=%0d: got %b expected 1", k, busy); end
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL 8n1_busy_end: got %b expected 0", busy); end
        n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL 8n1_tx_end: got %b expected 1", tx); end
    endtask
    task automatic test_7o2;
        logic [10:0] e;
        e = 11'b11011111110;
        baud_div = 16'd3; cfg_data_bits = 4'd7; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b1;
        wr_valid = 1'b1; wr_data = 9'h1ff;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 33; k++) begin
            n_checks++; if (tx !== e[k/3]) begin n_errs++; $display("FAIL 7o2_tx k=%0d: got %b expected %b", k, tx, e[k/3]); end
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL 7o2_busy_end: got %b expected 0", busy); end
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0; cfg_data_bits = 4'd8;
    endtask
    task automatic test_back_to_back;
        logic [8:0] words [17];
        logic       eb;
        for (int i = 0; i < 17; i++) words[i] = 9'(i * 37 + 5);
        tx_en = 1'b0; baud_div = 16'd0;
        wr_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = words[i];
            @(negedge clk);
        end
        wr_valid = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_errs++; $display("FAIL b2b_wr_ready_full: got %b expected 0", wr_ready); end
        n_checks++; if (fifo_count !== 5'd16) begin n_errs++; $display("FAIL b2b_count_full: got %0d expected 16", fifo_count); end
        tx_en = 1'b1;
        @(negedge clk);
        n_checks++; if (fifo_count !== 5'd15) begin n_errs++; $display("FAIL b2b_count_first_pop: got %0d expected 15", fifo_count); end
        for (int k = 0; k < 160; k++) begin
            eb = exp_bit(words[k/10], 8, 1'b0, 1'b0, k % 10);
            n_checks++; if (tx !== eb) begin n_errs++; $display("FAIL b2b_tx k=%0d: got %b expected %b", k, tx, eb); end
            n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL b2b_busy k=%0d: got %b expected 1", k, busy); end
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL b2b_count_end: got %0d expected 0", fifo_count); end
    endtask
    task automatic test_midframe;
        logic [8:0] wa, wb;
        logic       eb;
        wa = 9'h0a5; wb = 9'h1f3;
        baud_div = 16'd2; cfg_data_bits = 4'd8; tx_en = 1'b1;
        wr_valid = 1'b1; wr_data = wa;
        @(negedge clk);
        wr_data = wb;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            eb = exp_bit(wa, 8, 1'b0, 1'b0, k / 2);
            n_checks++; if (tx !== eb) begin n_errs++; $display("FAIL mid_frame1_tx k=%0d: got %b expected %b", k, tx, eb); end
            if (k == 5) begin cfg_data_bits = 4'd5; tx_en = 1'b0; end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL mid_busy_held: got %b expected 0", busy); end
        n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL mid_tx_held: got %b expected 1", tx); end
        n_checks++; if (fifo_count !== 5'd1) begin n_errs++; $display("FAIL mid_count_held: got %0d expected 1", fifo_count); end
        tx_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            eb = exp_bit(wb, 5, 1'b0, 1'b0, k / 2);
            n_checks++; if (tx !== eb) begin n_errs++; $display("FAIL mid_frame2_tx k=%0d: got %b expected %b", k, tx, eb); end
            @(negedge clk);
        end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL mid_busy_end: got %b expected 0", busy); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL mid_count_end: got %0d expected 0", fifo_count); end
        cfg_data_bits = 4'd8;
    endtask
    task automatic test_reset_midframe;
        baud_div = 16'd4; tx_en = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 9'(i * 2);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (tx !== 1'b0) begin n_errs++; $display("FAIL rstmid_tx_data0: got %b expected 0", tx); end
        n_checks++; if (fifo_count !== 5'd3) begin n_errs++; $display("FAIL rstmid_count_pre: got %0d expected 3", fifo_count); end
        rst = 1'b1;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (wr_ready !== 1'b1) begin n_errs++; $display("FAIL rstmid_wr_ready: got %b expected 1", wr_ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rstmid_no_restart: got %b expected 0", busy); end
        n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL rstmid_tx_idle: got %b expected 1", tx); end
    endtask
`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        baud_div = 16'd5; tx_en = 1'b1;
        brk = 1'b1; wr_valid = 1'b1; wr_data = 9'h0f0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            wr_valid = 1'b0;
            n_checks++; if (tx !== 1'b0) begin n_errs++; $display("FAIL brk_tx_low k=%0d: got %b expected 0", k, tx); end
            n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL brk_busy k=%0d: got %b expected 1", k, busy); end
        end
        brk = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (tx !== 1'b1) begin n_errs++; $display("FAIL brk_tx_release k=%0d: got %b expected 1", k, tx); end
        end
        @(negedge clk);
        n_checks++; if (tx !== 1'b0) begin n_errs++; $display("FAIL brk_frame_start: got %b expected 0", tx); end
        n_checks++; if (fifo_count !== 5'd0) begin n_errs++; $display("FAIL brk_count: got %0d expected 0", fifo_count); end
        repeat (60) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL brk_busy_end: got %b expected 0", busy); end
    endtask
`endif
    initial begin
        n_checks = 0; n_errs = 0;
        rst = 1'b1; baud_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0; tx_en = 1'b0; wr_valid = 1'b0; wr_data = '0; brk = 1'b0;
        test_reset;
        test_8n1;
        test_7o2;
        test_back_to_back;
        test_midframe;
        test_reset_midframe;
`ifdef UART_TX_BREAK_EN
        test_break;
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It serialises queued words onto `tx` at a runtime-programmable bit period, with runtime-selectable data width (5–9 bits), parity and stop-bit count. It is the next-generation replacement for the single-register transmitter: it buffers writes from the bus-side register block and sends back-to-back frames with no idle gap.

## Interface
**Parameters**
- `FIFO_DEPTH`, default 16: words of buffering; must be a power of two, ≥ 2.
- `DIV_WIDTH`, default 16: width of the bit-period divisor.

**Ports**
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `baud_div` input DIV_WIDTH: clock cycles per bit; values 0 and 1 both mean 1 cycle.
- `cfg_data_bits` input 4: data bits per frame; values < 5 clamp to 5, values > 9 clamp to 9.
- `cfg_parity_en` input 1: append a parity bit.
- `cfg_parity_odd` input 1: 1 = odd parity, 0 = even parity.
- `cfg_stop2` input 1: 1 = two stop bits, 0 = one stop bit.
- `tx_en` input 1: permit new frames to start.
- `wr_valid` input 1: write request.
- `wr_data` input 9: word to queue; only the low D bits are sent.
- `wr_ready` output 1: FIFO can accept a word.
- `brk` input 1: break request; used only under `UART_TX_BREAK_EN`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame or break is in progress.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: words queued.

## Operation
- Push: on a rising edge where `wr_valid && wr_ready`, the FIFO stores `wr_data`.
- `wr_ready = (fifo_count < FIFO_DEPTH)`. It is registered-state derived, so a pop in the same cycle does not make a full FIFO ready.
- FSM states: IDLE, START, DATA, PARITY, STOP, and BREAK (BREAK exists only when the macro is defined).
- IDLE → START: on an edge where `tx_en=1` and `fifo_count≠0`, the FSM pops the head word.
  - At that same edge it latches the frame config: D (clamped), parity_en, parity_odd, stop2, and the effective divisor.
  - Config or divisor changes mid-frame therefore have no effect on the current frame.
- Per-state line behaviour:
  - START: `tx=0`.
  - DATA: sends D bits, LSB first.
  - PARITY: present only if parity_en. Bit value = XOR of the D sent bits; inverted when odd.
  - STOP: `tx=1` for 1 or 2 bit periods.
- Every bit is held for exactly the latched divisor count of cycles.
- End of frame (last cycle of the final stop bit):
  - If `tx_en=1` and the FIFO is non-empty, the FSM pops and goes directly to START, with no idle cycles between frames.
  - Otherwise it goes to IDLE.
- `tx_en` deasserted mid-frame: the current frame completes and no new pop occurs.
- Simultaneous push and pop: `fifo_count` is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `tx=1`, `busy=0`, `wr_ready=1`, `fifo_count=0`, FSM=IDLE. The FIFO and bit counters are cleared.
- Reset asserted mid-frame returns `tx` to 1 immediately (asynchronous). All queued words are discarded.
- Latency from empty and idle:
  - Word written at edge N, so `fifo_count=1` after N.
  - Pop at edge N+1; `tx` falls after N+1.
- Frame length = B·(1 + D + P + S) cycles, where B = max(`baud_div`,1), P ∈ {0,1}, S ∈ {1,2}.
- `busy`:
  - Goes high at the pop edge.
  - Goes low at the edge that enters IDLE.
  - Stays high continuously across back-to-back frames.
- `fifo_count` updates on the edge of the push or pop.

## Configuration
- Macro `UART_TX_BREAK_EN`.
- Defined:
  - In IDLE, `brk=1` takes priority over a pending pop. The FSM enters BREAK, with `tx=0` and `busy=1` for as long as `brk` is held.
  - When `brk` falls, `tx=1` for one full bit period B, then IDLE.
  - `brk` asserted mid-frame is ignored until the frame ends.
- Not defined: the `brk` port exists but is ignored; BREAK logic is absent.

## Test plan
- **Basic 8N1:** `baud_div=4`, D=8, no parity, one stop bit; write 0x55.
  - `tx` = 0, 1,0,1,0,1,0,1,0, 1, each level held 4 cycles; total 40 cycles.
  - `busy` is high for exactly 40 cycles.
- **7O2:** `baud_div=3`, D=7, odd parity, two stop bits; write 0x1FF.
  - Data bits are seven 1s, parity bit = 0, then two stop bits.
  - Frame is 33 cycles; the bit-8 data above D is not sent.
- **Back-to-back and full:** `tx_en=0`, FIFO_DEPTH=16; write 17 words with `wr_valid` held.
  - 16 accepted, `wr_ready=0`, `fifo_count=16`.
  - Raise `tx_en`: 16 frames go out with no idle cycles between them, then `busy=0` and `fifo_count=0`.
- **Config and enable changes mid-frame:** change `cfg_data_bits` 8→5 and drop `tx_en` during frame 1.
  - Frame 1 stays 8-bit.
  - No frame 2 starts until `tx_en=1`; frame 2 then uses D=5.
- **Reset mid-frame:** assert `rst` during a data bit with 3 words queued.
  - `tx=1` immediately; `fifo_count=0`, `busy=0`, `wr_ready=1`.
- **Break (`UART_TX_BREAK_EN`):** `baud_div=5`, hold `brk` 30 cycles while one word is queued.
  - `tx=0` for 30 cycles, then `tx=1` for 5 cycles, then the queued frame starts.
